aes128_iter_core: RTL
=====================

Name: aes128_iter_core

Overview:
- Sequential, handshake-driven AES-128 encryption core. Successor to the purely combinational aes block.
- Computes UNROLL rounds per clock with on-the-fly key expansion. Returns the ciphertext and the final (round-10) round key.
- Sits between a block-source FIFO and a result sink. Uses a valid/ready handshake on both sides.

Parameters:
- UNROLL, 1, AES rounds per clock. Legal values are 1, 2, 5, 10. Any other value must fail elaboration.
- NCYC, 10/UNROLL, derived localparam: number of round cycles per block.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext/key presented
- in_ready  output  1  core can accept a block
- plaintext  input  128  state input, FIPS-197 byte order (byte 0 = [127:120])
- key  input  128  cipher key, same byte order
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- cipher_text  output  128  encrypted block
- keyout  output  128  round-10 round key

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE, round counter=0.
  - State register, round-key register, cipher_text and keyout all cleared to 0.
  - out_valid=0.
  - in_ready is combinational (state==IDLE), so it reads 1 from reset onward.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On (in_valid & in_ready):
    - capture state <= plaintext ^ key and rkey <= key; rcnt <= 0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - apply UNROLL rounds to state;
    - expand rkey UNROLL times, using Rcon indexed by absolute round number;
    - rcnt += UNROLL.
    - The round with absolute index 10 omits MixColumns.
    - When the cycle computing round 10 completes: load cipher_text and keyout, go to DONE.
  - DONE: out_valid=1. cipher_text and keyout are stable.
    - On (out_valid & out_ready): go to IDLE.
- Latency: accept edge at cycle T; out_valid rises after edge T+NCYC.
  - NCYC is 10 / 5 / 2 / 1 for UNROLL = 1 / 2 / 5 / 10.
  - Minimum block period is NCYC+2 cycles: accept, NCYC round cycles, result handshake.
  - No overlap: in_ready stays 0 in DONE, even when out_ready=1.
- Inputs are sampled only on the accept edge. Changes to plaintext/key while in RUN or DONE have no effect.
- in_valid while not in_ready: ignored. The producer must hold the block until accepted.
- out_ready while not out_valid: ignored.
- cipher_text/keyout keep their last completed values after the handshake and through IDLE/RUN. They update only on completion. Before the first completion they read 0.
- Backpressure: DONE holds indefinitely while out_ready=0. Outputs are constant throughout.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The partial block is discarded and no out_valid pulse is emitted.
- Arithmetic and round functions:
  - SubBytes uses the combinational FIPS-197 S-box. With UNROLL=1 that is 16 instances for the state and 4 for key expansion.
  - MixColumns uses xtime over GF(2^8) with polynomial 0x11B.
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- rcnt is 4 bits and never exceeds 10. Values above 10 are unreachable; an assertion flags them.

Test Plan:
- FIPS-197 App. B, UNROLL=1:
  - stimulus: plaintext=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c;
  - expected: cipher_text=3925841d02dc09fbdc118597196a0b32, keyout=d014f9a8c9ee2589e13f0cc8b6630ca6, out_valid exactly 10 cycles after accept.
- FIPS-197 App. C.1:
  - stimulus: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f;
  - expected: cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a, keyout=13111d7fe3944a17f307a78b4d2b30c5;
  - run for each UNROLL in {1,2,5,10}; latency must equal 10/5/2/1 respectively.
- Backpressure: hold out_ready=0 for 20 cycles after completion.
  - Expected: out_valid held at 1, outputs constant, in_ready=0.
  - Then pulse out_ready for 1 cycle: in_ready=1 the next cycle. Drive in_valid=1 while in RUN: no second capture.
- Reset mid-RUN: assert rst_n=0 at round 5 of the App. B vector.
  - Expected: out_valid=0, cipher_text=0, in_ready=1.
  - A new App. C.1 block afterwards must produce the correct C.1 result.
- Input hold check: change plaintext/key every cycle during RUN.
  - Expected: the result matches the block captured at the accept edge.
- Random regression: 1000 random blocks with random in_valid/out_ready gaps, checked against a reference-model scoreboard; no loss or duplication of blocks.

Source files
------------

// File: rtl/aes128_iter_core.sv
`timescale 1ns/1ps
// AES-128 encryption core: UNROLL rounds per clock with on-the-fly key expansion,
// valid/ready handshake on the block input and on the result output.
module aes128_iter_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
    output logic [127:0] keyout
);
    localparam int         NCYC      = 10 / UNROLL;
    localparam logic [3:0] LAST_RCNT = 4'(UNROLL * (NCYC - 1));

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_reg;
    logic [3:0]   rcnt_reg;
    logic [127:0] data_reg;
    logic [127:0] rkey_reg;
    logic [127:0] data_next;
    logic [127:0] rkey_next;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        // RotWord then SubWord on the last word, Rcon folded into its leading byte
        t  = {sub_byte(w3[23:16]) ^ rc, sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b  [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3, all;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            b[i] = sub_byte(s[127 - 8 * i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                sr[4 * c + row] = b[4 * ((c + row) % 4) + row];
            end
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0  = sr[4 * c];
            a1  = sr[4 * c + 1];
            a2  = sr[4 * c + 2];
            a3  = sr[4 * c + 3];
            all = a0 ^ a1 ^ a2 ^ a3;
            if (last) begin
                r[127 - 32 * c -: 32] = {a0, a1, a2, a3};
            end else begin
                r[127 - 32 * c -: 32] = {a0 ^ all ^ xtime(a0 ^ a1), a1 ^ all ^ xtime(a1 ^ a2),
                                         a2 ^ all ^ xtime(a2 ^ a3), a3 ^ all ^ xtime(a3 ^ a0)};
            end
        end
        return r ^ rk;
    endfunction

    // Combinational chain of UNROLL rounds; each stage derives its own absolute round number.
    genvar gi;
    generate
        for (gi = 0; gi < UNROLL; gi++) begin : g_round
            logic [127:0] st_in, rk_in, st_out, rk_out;
            logic [3:0]   rnd;
            if (gi == 0) begin : g_head
                assign st_in = data_reg;
                assign rk_in = rkey_reg;
            end else begin : g_link
                assign st_in = g_round[gi-1].st_out;
                assign rk_in = g_round[gi-1].rk_out;
            end
            assign rnd    = rcnt_reg + 4'(gi + 1);
            assign rk_out = next_key(rk_in, rcon(rnd));
            assign st_out = aes_round(st_in, rk_out, rnd == 4'd10);
        end
    endgenerate

    assign data_next = g_round[UNROLL-1].st_out;
    assign rkey_next = g_round[UNROLL-1].rk_out;
    assign in_ready  = (fsm_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg     <= IDLE;
            rcnt_reg    <= '0;
            data_reg    <= '0;
            rkey_reg    <= '0;
            cipher_text <= '0;
            keyout      <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= plaintext ^ key;
                        rkey_reg <= key;
                        rcnt_reg <= '0;
                        fsm_reg  <= RUN;
                    end
                end
                RUN: begin
                    data_reg <= data_next;
                    rkey_reg <= rkey_next;
                    rcnt_reg <= rcnt_reg + 4'(UNROLL);
                    if (rcnt_reg == LAST_RCNT) begin
                        cipher_text <= data_next;
                        keyout      <= rkey_next;
                        out_valid   <= 1'b1;
                        fsm_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm_reg   <= IDLE;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

    a_rcnt_range: assert property (@(posedge clk) disable iff (!rst_n) rcnt_reg <= 4'd10);

endmodule
